serial_adder: RTL

Bit-serial WIDTH-bit adder: latches two operands and a carry-in on a start strobe, then adds one bit per clock, LSB first, through a single full-adder cell and a carry flop. It trades latency for area against the ripple-style parallel arithmetic in the same library. Subtraction is obtained by the caller presenting the inverted subtrahend with carryIn=1. The result is held in an output register and announced with a one-cycle done pulse.

---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/serial_adder_full_adder.sv | 19 +
 rtl/serial_adder.sv | 95 +++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_adder_pkg                                                       |
// | FSM state encoding and counter sizing shared by the serial adder.      |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
package serial_adder_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADD  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Bit counter width: counts 0..WIDTH-1.
   function automatic int cnt_width(input int width);
      return $clog2(width);
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_full_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_adder_full_adder                                                |
// | Single-bit combinational full-adder cell.                              |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module serial_adder_full_adder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_s,
   output logic o_cout
);

   assign o_s    = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_adder                                                           |
// | Bit-serial WIDTH-bit adder, LSB first, one full-adder cell + carry FF. |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carryIn,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carryOut
);

   localparam int               CNT_W  = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;
   logic             r_carry;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry_out;

   logic             w_sum_bit;
   logic             w_cout;
   logic             w_accept;
   logic [WIDTH-1:0] w_shift_next;

   serial_adder_full_adder u_fa (
      .i_a    (r_op_a[0]),
      .i_b    (r_op_b[0]),
      .i_cin  (r_carry),
      .o_s    (w_sum_bit),
      .o_cout (w_cout)
   );

   // A new request is only taken when no addition is in progress.
   assign w_accept     = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_shift_next = {w_sum_bit, r_shift[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_carry     <= 1'b0;
         r_count     <= '0;
         r_shift     <= '0;
         r_sum       <= '0;
         r_carry_out <= 1'b0;
      end else if (w_accept) begin
         r_op_a  <= a;
         r_op_b  <= b;
         r_carry <= carryIn;
         r_count <= '0;
         r_state <= ADD;
      end else begin
         case (r_state)
            ADD: begin
               r_shift <= w_shift_next;
               r_op_a  <= r_op_a >> 1;
               r_op_b  <= r_op_b >> 1;
               r_carry <= w_cout;
               r_count <= r_count + 1'b1;
               // Result becomes visible only once the last bit is formed.
               if (r_count == C_LAST) begin
                  r_sum       <= w_shift_next;
                  r_carry_out <= w_cout;
                  r_state     <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy     = (r_state == ADD);
   assign done     = (r_state == DONE);
   assign sum      = r_sum;
   assign carryOut = r_carry_out;

endmodule
`default_nettype wire
